// File: rtl/router_fsm.sv
// router_fsm: control state machine for the 1x3 router.
// Sequences the register block strobes, FIFO write enable and source busy.
// All outputs come straight from flops: each one is decoded from the next
// state and registered, so it always matches the current state.
module router_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    // Output vector bit order:
    // {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy}
    localparam logic [7:0] OUT_RESET = 8'b1000_0000;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] out_q, out_d;

    logic [1:0] sel_addr_s;
    logic       sel_empty_s;
    logic       sel_soft_reset_s;

    // Moore decode of a state into the strobe/enable/busy vector.
    function automatic logic [7:0] decode_outputs(input state_t s);
        logic [7:0] v;
        case (s)
            DECODE_ADDRESS:     v = 8'b1000_0000;
            LOAD_FIRST_DATA:    v = 8'b0100_0001;
            LOAD_DATA:          v = 8'b0010_0010;
            LOAD_AFTER_FULL:    v = 8'b0001_0011;
            FIFO_FULL_STATE:    v = 8'b0000_1001;
            CHECK_PARITY_ERROR: v = 8'b0000_0101;
            LOAD_PARITY:        v = 8'b0000_0011;
            WAIT_TILL_EMPTY:    v = 8'b0000_0001;
            default:            v = 8'b1000_0000;
        endcase
        return v;
    endfunction

    // Pick the empty flag (live address while decoding, latched address otherwise)
    // and the soft reset of the FIFO this packet is bound for.
    always_comb begin
        sel_addr_s       = addr_q;
        sel_empty_s      = 1'b0;
        sel_soft_reset_s = 1'b0;
        if (state_q == DECODE_ADDRESS) begin
            sel_addr_s = data_in;
        end else begin
            sel_addr_s = addr_q;
        end
        case (sel_addr_s)
            2'd0:    sel_empty_s = fifo_empty_0;
            2'd1:    sel_empty_s = fifo_empty_1;
            2'd2:    sel_empty_s = fifo_empty_2;
            default: sel_empty_s = 1'b0;
        endcase
        case (addr_q)
            2'd0:    sel_soft_reset_s = soft_reset_0;
            2'd1:    sel_soft_reset_s = soft_reset_1;
            2'd2:    sel_soft_reset_s = soft_reset_2;
            default: sel_soft_reset_s = 1'b0;
        endcase
    end

    // Next-state, address capture and next-output computation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if ((state_q == DECODE_ADDRESS) && pkt_valid) begin
            addr_d = data_in;
        end else begin
            addr_d = addr_q;
        end

        if ((state_q != DECODE_ADDRESS) && sel_soft_reset_s) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid && (data_in != 2'd3) && sel_empty_s) begin
                        state_d = LOAD_FIRST_DATA;
                    end else if (pkt_valid && (data_in != 2'd3)) begin
                        state_d = WAIT_TILL_EMPTY;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                    end else begin
                        state_d = FIFO_FULL_STATE;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty_s) begin
                        state_d = LOAD_FIRST_DATA;
                    end else begin
                        state_d = WAIT_TILL_EMPTY;
                    end
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end

        out_d = decode_outputs(state_d);
    end

    // State, latched address and registered outputs; reset is synchronous.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
            out_q   <= OUT_RESET;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
        end
    end

    assign detect_add    = out_q[7];
    assign lfd_state     = out_q[6];
    assign ld_state      = out_q[5];
    assign laf_state     = out_q[4];
    assign full_state    = out_q[3];
    assign rst_int_reg   = out_q[2];
    assign write_enb_reg = out_q[1];
    assign busy          = out_q[0];

endmodule

// File: tb/tb_router_fsm.sv
// Directed testbench for router_fsm with hand-computed expected output vectors.
module tb_router_fsm;

    logic       clock;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       write_enb_reg, detect_add, lfd_state, ld_state;
    logic       laf_state, full_state, rst_int_reg, busy;

    int checks = 0;
    int errors = 0;

    // {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy}
    localparam logic [7:0] E_DA   = 8'b1000_0000;
    localparam logic [7:0] E_LFD  = 8'b0100_0001;
    localparam logic [7:0] E_LD   = 8'b0010_0010;
    localparam logic [7:0] E_LAF  = 8'b0001_0011;
    localparam logic [7:0] E_FULL = 8'b0000_1001;
    localparam logic [7:0] E_CPE  = 8'b0000_0101;
    localparam logic [7:0] E_LP   = 8'b0000_0011;
    localparam logic [7:0] E_WTE  = 8'b0000_0001;

    router_fsm dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .write_enb_reg (write_enb_reg),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, write_enb_reg, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        tick(); tick();
        check("reset", E_DA);
        reset = 1'b0;

        // Idle.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle", E_DA);
        end

        // Packet to addr 2, 14 payload bytes.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b1;
        tick(); check("p1_lfd", E_LFD);
        for (int i = 0; i < 14; i++) begin
            tick(); check("p1_ld", E_LD);
        end
        pkt_valid = 1'b0;
        tick(); check("p1_lp", E_LP);
        tick(); check("p1_cpe", E_CPE);
        tick(); check("p1_da", E_DA);

        // Packet to addr 1 while FIFO 1 is busy; a different empty flag on the bus must not matter.
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b0;
        tick(); check("p2_wte", E_WTE);
        data_in = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick(); check("p2_wte_hold", E_WTE);
        end
        fifo_empty_1 = 1'b1;
        tick(); check("p2_lfd", E_LFD);
        for (int i = 0; i < 4; i++) begin
            tick(); check("p2_ld", E_LD);
        end
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("p2_full", E_FULL);
        end
        fifo_full = 1'b0;
        tick(); check("p2_laf", E_LAF);
        tick(); check("p2_back_ld", E_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        tick(); check("full_over_parity", E_FULL);
        fifo_full = 1'b0;
        tick(); check("p2_laf2", E_LAF);
        low_pkt_valid = 1'b1;
        tick(); check("laf_low_pkt", E_LP);
        low_pkt_valid = 1'b0;
        fifo_full = 1'b1;
        tick(); check("cpe_before_full", E_CPE);
        tick(); check("cpe_full", E_FULL);
        fifo_full = 1'b0;
        tick(); check("p2_laf3", E_LAF);
        parity_done = 1'b1;
        tick(); check("laf_parity_done", E_DA);
        parity_done = 1'b0;

        // Soft resets during an addr-2 packet.
        pkt_valid = 1'b1; data_in = 2'd2;
        tick(); check("p3_lfd", E_LFD);
        tick(); check("p3_ld", E_LD);
        soft_reset_0 = 1'b1;
        tick(); check("soft0_ignored", E_LD);
        soft_reset_0 = 1'b0; soft_reset_2 = 1'b1;
        tick(); check("soft2_abort", E_DA);
        soft_reset_2 = 1'b0; pkt_valid = 1'b0;
        tick(); check("p3_idle", E_DA);

        // Address 3 is never accepted.
        pkt_valid = 1'b1; data_in = 2'd3; fifo_empty_0 = 1'b1;
        tick(); check("addr3", E_DA);
        tick(); check("addr3_hold", E_DA);

        // Soft reset beats sel_empty in WAIT_TILL_EMPTY.
        data_in = 2'd0; fifo_empty_0 = 1'b0;
        tick(); check("p4_wte", E_WTE);
        pkt_valid = 1'b0; fifo_empty_0 = 1'b1; soft_reset_0 = 1'b1;
        tick(); check("wte_soft_wins", E_DA);
        soft_reset_0 = 1'b0;

        // Reset mid-packet.
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(); check("p5_lfd", E_LFD);
        tick(); check("p5_ld", E_LD);
        reset = 1'b1;
        tick(); check("mid_reset", E_DA);
        reset = 1'b0; pkt_valid = 1'b0;
        tick(); check("post_reset", E_DA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
